// File: rtl/fft_tile_sched.sv
// Tile scheduler for a 2-D FFT engine: issues image-memory reads and FFT input strobes,
// bounds tiles in flight, and writes FFT output tiles back to memory.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing tiles and writing returned tiles
// DRAIN | all tiles issued, waiting for the remaining outputs
// DONE  | one-cycle completion pulse
module fft_tile_sched #(
  parameter int ISSUE_GAP = 1,
  parameter int MAX_OUT   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [12:0] num_tiles,
  input  logic [12:0] rd_base,
  input  logic [12:0] wr_base,
  output logic [12:0] mem_read_address,
  output logic        fft_next,
  input  logic        fft_next_out,
  output logic        mem_we,
  output logic [12:0] mem_write_address,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [12:0] num_q, num_d;
  logic [12:0] rd_base_q, rd_base_d;
  logic [12:0] wr_base_q, wr_base_d;
  logic [12:0] issue_cnt_q, issue_cnt_d;
  logic [12:0] wr_cnt_q, wr_cnt_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [3:0]  gap_q, gap_d;
  logic        next_q, next_d;
  logic        err_q, err_d;
  logic        active, issue, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      num_q         <= '0;
      rd_base_q     <= '0;
      wr_base_q     <= '0;
      issue_cnt_q   <= '0;
      wr_cnt_q      <= '0;
      outstanding_q <= '0;
      gap_q         <= '0;
      next_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      rd_base_q     <= rd_base_d;
      wr_base_q     <= wr_base_d;
      issue_cnt_q   <= issue_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      outstanding_q <= outstanding_d;
      gap_q         <= gap_d;
      next_q        <= next_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    rd_base_d     = rd_base_q;
    wr_base_d     = wr_base_q;
    issue_cnt_d   = issue_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    outstanding_d = outstanding_q;
    gap_d         = gap_q;
    err_d         = err_q;

    active = (state_q == S_RUN) || (state_q == S_DRAIN);
    // outstanding_q already counts the tile whose fft_next is still pending
    accept = fft_next_out && active && (outstanding_q != 4'd0);
    issue  = (state_q == S_RUN) && !abort && (issue_cnt_q < num_q) &&
             (outstanding_q < 4'(MAX_OUT)) && (gap_q == 4'd0);
    next_d = issue;

    if (issue) begin
      issue_cnt_d = issue_cnt_q + 13'd1;
      gap_d       = 4'(ISSUE_GAP - 1);
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end
    if (accept) wr_cnt_d = wr_cnt_q + 13'd1;
    if (issue && !accept) outstanding_d = outstanding_q + 4'd1;
    else if (!issue && accept) outstanding_d = outstanding_q - 4'd1;
    if (fft_next_out && !accept) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d         = num_tiles;
          rd_base_d     = rd_base;
          wr_base_d     = wr_base;
          issue_cnt_d   = '0;
          wr_cnt_d      = '0;
          outstanding_d = '0;
          gap_d         = '0;
          err_d         = 1'b0;
          state_d       = (num_tiles == 13'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issue_cnt_q + 13'd1 == num_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (accept && (wr_cnt_q + 13'd1 == num_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (active && abort) begin
      state_d       = S_IDLE;
      issue_cnt_d   = '0;
      wr_cnt_d      = '0;
      outstanding_d = '0;
      gap_d         = '0;
      next_d        = 1'b0;
    end
  end

  assign mem_read_address  = (state_q == S_RUN) ? rd_base_q + issue_cnt_q : 13'd0;
  assign mem_write_address = wr_base_q + wr_cnt_q;
  assign fft_next          = next_q;
  assign mem_we            = accept;
  assign busy              = active;
  assign done              = (state_q == S_DONE);
  assign err               = err_q;

endmodule

// File: tb/tb_fft_tile_sched.sv
// Directed bench for fft_tile_sched: default instance for job vectors and corner cases,
// a MAX_OUT=2 instance for the in-flight limit; FFT engine modelled as a delay line.
module tb_fft_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0, force_a = 1'b0;
  logic [12:0] num_a = '0, rd_a = '0, wr_a = '0;
  logic [12:0] mem_read_address_a, mem_write_address_a;
  logic        fft_next_a, fft_out_a, mem_we_a, busy_a, done_a, err_a;
  logic [15:0] sr_a;
  int          lat_a = 1;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [12:0] num_b = '0, rd_b = '0, wr_b = '0;
  logic [12:0] mem_read_address_b, mem_write_address_b;
  logic        fft_next_b, fft_out_b, mem_we_b, busy_b, done_b, err_b;
  logic [15:0] sr_b;
  int          lat_b = 10;

  int errors = 0;
  int checks = 0;

  fft_tile_sched u_a (
    .clk(clk), .reset(rst_n), .start(start_a), .abort(abort_a),
    .num_tiles(num_a), .rd_base(rd_a), .wr_base(wr_a),
    .mem_read_address(mem_read_address_a), .fft_next(fft_next_a),
    .fft_next_out(fft_out_a), .mem_we(mem_we_a),
    .mem_write_address(mem_write_address_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  fft_tile_sched #(.ISSUE_GAP(1), .MAX_OUT(2)) u_b (
    .clk(clk), .reset(rst_n), .start(start_b), .abort(abort_b),
    .num_tiles(num_b), .rd_base(rd_b), .wr_base(wr_b),
    .mem_read_address(mem_read_address_b), .fft_next(fft_next_b),
    .fft_next_out(fft_out_b), .mem_we(mem_we_b),
    .mem_write_address(mem_write_address_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // FFT engine: output strobe exactly lat cycles after the input strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      sr_a <= {sr_a[14:0], fft_next_a};
      sr_b <= {sr_b[14:0], fft_next_b};
    end
  end
  assign fft_out_a = sr_a[lat_a-1] | force_a;
  assign fft_out_b = sr_b[lat_b-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [12:0] n, rd, wr;
    int          lat;
    logic [12:0] last_rd, last_wr;
    int          done_cyc;
  } vec_t;
  vec_t vecs[5];

  // Cycle 0 is the first cycle after the edge that samples start.
  task automatic run_a(input vec_t v, input int idx);
    logic [12:0] prev_rd, first_rd, last_rd, first_wr, last_wr;
    int nrd, nwr, done_c, last_iss, seq_bad;
    nrd = 0; nwr = 0; done_c = -1; last_iss = -1; seq_bad = 0;
    prev_rd = '0; first_rd = '0; last_rd = '0; first_wr = '0; last_wr = '0;
    lat_a = v.lat; num_a = v.n; rd_a = v.rd; wr_a = v.wr; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk($sformatf("v%0d_busy_c0", idx), {31'd0, busy_a}, {31'd0, v.n != 13'd0});
    for (int c = 0; c < 300; c++) begin
      if (fft_next_a) begin
        if (nrd == 0) first_rd = prev_rd;
        else if (prev_rd != last_rd + 13'd1) seq_bad++;
        last_rd = prev_rd; last_iss = c - 1; nrd++;
      end
      if (mem_we_a) begin
        if (nwr == 0) first_wr = mem_write_address_a;
        else if (mem_write_address_a != last_wr + 13'd1) seq_bad++;
        last_wr = mem_write_address_a; nwr++;
      end
      if (done_a) begin
        done_c = c;
        break;
      end
      prev_rd = mem_read_address_a;
      @(negedge clk);
    end
    chk($sformatf("v%0d_reads", idx), nrd, {19'd0, v.n});
    chk($sformatf("v%0d_writes", idx), nwr, {19'd0, v.n});
    chk($sformatf("v%0d_done_cycle", idx), done_c, v.done_cyc);
    chk($sformatf("v%0d_addr_seq", idx), seq_bad, 0);
    chk($sformatf("v%0d_busy_at_done", idx), {31'd0, busy_a}, 32'd0);
    if (v.n != 13'd0) begin
      chk($sformatf("v%0d_first_rd", idx), first_rd, v.rd);
      chk($sformatf("v%0d_last_rd", idx), last_rd, v.last_rd);
      chk($sformatf("v%0d_first_wr", idx), first_wr, v.wr);
      chk($sformatf("v%0d_last_wr", idx), last_wr, v.last_wr);
      chk($sformatf("v%0d_last_issue", idx), last_iss, int'(v.n) - 1);
    end
    @(negedge clk);
  endtask

  initial begin
    int nfn, nwe, ndone, inflight, max_inflight, done_c;
    logic [12:0] last_wr;

    vecs[0] = '{13'd4, 13'h010, 13'h100, 6, 13'h013, 13'h103, 11};
    vecs[1] = '{13'd3, 13'h1FFE, 13'h1FFF, 2, 13'h0000, 13'h0001, 6};
    vecs[2] = '{13'd1, 13'h005, 13'h0AA, 1, 13'h005, 13'h0AA, 3};
    vecs[3] = '{13'd0, 13'h123, 13'h456, 3, 13'h000, 13'h000, 0};
    vecs[4] = '{13'd6, 13'h0FF, 13'h000, 4, 13'h104, 13'h005, 11};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_addr", {19'd0, mem_read_address_a}, 32'd0);
    chk("rst_wr_addr", {19'd0, mem_write_address_a}, 32'd0);
    chk("rst_outs", {28'd0, fft_next_a, mem_we_a, busy_a, done_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);

    for (int i = 0; i < 5; i++) run_a(vecs[i], i);

    // spurious FFT output while idle
    force_a = 1'b1;
    #1;
    chk("spur_we", {31'd0, mem_we_a}, 32'd0);
    @(negedge clk);
    force_a = 1'b0;
    chk("spur_err", {31'd0, err_a}, 32'd1);
    run_a(vecs[2], 5);
    chk("spur_err_cleared", {31'd0, err_a}, 32'd0);

    // abort while the third tile is being issued
    lat_a = 6; num_a = 13'd4; rd_a = 13'h040; wr_a = 13'h080; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_fn", {31'd0, fft_next_a}, 32'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    nfn = 0; nwe = 0; ndone = 0;
    for (int c = 0; c < 15; c++) begin
      nfn += int'(fft_next_a); nwe += int'(mem_we_a); ndone += int'(done_a);
      @(negedge clk);
    end
    chk("abort_no_fn", nfn, 0);
    chk("abort_no_we", nwe, 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_late_out_err", {31'd0, err_a}, 32'd1);

    // reset in DRAIN with two tiles outstanding
    lat_a = 6; num_a = 13'd4; rd_a = 13'h010; wr_a = 13'h100; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("drain_busy", {31'd0, busy_a}, 32'd1);
    chk("drain_we", {31'd0, mem_we_a}, 32'd1);
    chk("drain_wr_addr", {19'd0, mem_write_address_a}, 32'h102);
    rst_n = 1'b0;
    #1;
    chk("arst_addrs", {6'd0, mem_read_address_a, mem_write_address_a}, 32'd0);
    chk("arst_outs", {27'd0, fft_next_a, mem_we_a, busy_a, done_a, err_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; nwe = 0;
    for (int c = 0; c < 15; c++) begin
      ndone += int'(done_a); nwe += int'(mem_we_a);
      @(negedge clk);
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_no_we", nwe, 0);
    chk("arst_idle", {30'd0, busy_a, err_a}, 32'd0);

    // in-flight limit of two with a long FFT latency
    num_b = 13'd5; rd_b = 13'h200; wr_b = 13'h300; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nfn = 0; nwe = 0; inflight = 0; max_inflight = 0; done_c = -1; last_wr = '0;
    for (int c = 0; c < 300; c++) begin
      inflight += int'(fft_next_b) - int'(fft_out_b);
      if (inflight > max_inflight) max_inflight = inflight;
      nfn += int'(fft_next_b);
      if (mem_we_b) begin
        nwe++;
        last_wr = mem_write_address_b;
      end
      if (done_b) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    chk("lim_max_inflight", max_inflight, 2);
    chk("lim_fft_next", nfn, 5);
    chk("lim_writes", nwe, 5);
    chk("lim_last_wr", {19'd0, last_wr}, 32'h304);
    chk("lim_done_cycle", done_c, 36);
    chk("lim_err", {31'd0, err_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_tile_sched.md
FFT_TILE_SCHED -- requirements
Module: fft_tile_sched

Interface
REQ-001 Parameter ISSUE_GAP, default 1: minimum cycles between consecutive tile issues (legal range 1..15).
REQ-002 Parameter MAX_OUT, default 8: maximum tiles in flight inside the 2-D FFT engine (legal range 1..15).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a job when idle.
REQ-006 abort  in  1  one-cycle pulse; cancels the current job.
REQ-007 num_tiles  in  13  tile count for the job; latched at start.
REQ-008 rd_base  in  13  first image-memory read address; latched at start.
REQ-009 wr_base  in  13  first image-memory write address; latched at start.
REQ-010 mem_read_address  out  13  image memory read address (memory read latency 1 cycle).
REQ-011 fft_next  out  1  strobe to 2-D FFT engine: input tile valid this cycle.
REQ-012 fft_next_out  in  1  strobe from FFT engine: output tile valid this cycle.
REQ-013 mem_we  out  1  image memory write enable.
REQ-014 mem_write_address  out  13  image memory write address.
REQ-015 busy  out  1  job in progress.
REQ-016 done  out  1  one-cycle pulse at normal job completion.
REQ-017 err  out  1  sticky: fft_next_out received with zero tiles outstanding.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start latches num_tiles/rd_base/wr_base, clears issue_cnt, wr_cnt, outstanding, gap counter; next state RUN (or DONE if num_tiles==0).
REQ-020 RUN issue condition: issue_cnt<num_tiles, outstanding<MAX_OUT, gap counter expired.
REQ-021 On issue in cycle t: mem_read_address=rd_base+issue_cnt (mod 2^13) is presented in cycle t; issue_cnt increments; gap counter reloads ISSUE_GAP-1.
REQ-022 fft_next SHALL be high exactly in cycle t+1 for each issue in cycle t, aligned with memory read data; never high otherwise.
REQ-023 outstanding increments on fft_next, decrements on accepted fft_next_out; both in same cycle leaves it unchanged.
REQ-024 Stall counting: outstanding includes the tile whose fft_next is pending, so at most MAX_OUT tiles are ever in flight.
REQ-025 RUN -> DRAIN when issue_cnt reaches num_tiles.
REQ-026 Accepted fft_next_out (state RUN or DRAIN, outstanding>0 after REQ-023 accounting): mem_we=1 and mem_write_address=wr_base+wr_cnt (mod 2^13) in the same cycle (combinational from fft_next_out); wr_cnt increments.
REQ-027 fft_next_out with outstanding==0, or in IDLE/DONE: mem_we stays 0, err sets, counters unchanged.
REQ-028 DRAIN -> DONE when wr_cnt reaches num_tiles; DONE lasts one cycle with done=1, then IDLE.
REQ-029 busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-030 start while not IDLE is ignored.
REQ-031 abort in RUN/DRAIN: next state IDLE, counters cleared, no done pulse, pending fft_next suppressed; abort in IDLE/DONE ignored; abort and start same cycle in IDLE: start wins.
REQ-032 err clears only on reset or on an accepted start.
REQ-033 Address counters wrap modulo 2^13 without error.

Reset
REQ-034 Asserting reset immediately forces IDLE; mem_read_address=0, mem_write_address=0, fft_next=0, mem_we=0, busy=0, done=0, err=0, all counters 0, including mid-job.

Verification
REQ-035 num_tiles=4, rd_base=0x010, wr_base=0x100, ISSUE_GAP=1, FFT latency 6 -> reads 0x010..0x013 consecutive cycles, fft_next one cycle later each, writes 0x100..0x103, done one cycle after last write.
REQ-036 MAX_OUT=2, FFT latency 10, num_tiles=5 -> never more than 2 fft_next without matching fft_next_out; all 5 written.
REQ-037 rd_base=0x1FFE, num_tiles=3 -> reads 0x1FFE, 0x1FFF, 0x0000.
REQ-038 num_tiles=0 -> no fft_next, no mem_we, done pulses one cycle after start state RUN skipped.
REQ-039 Spurious fft_next_out in IDLE -> err=1, mem_we=0; next start clears err.
REQ-040 reset low mid-DRAIN with 2 outstanding -> all outputs 0 asynchronously; no done.
